// File: rtl/trafparser_pkg.sv
// Shared types for the trafparser source arbiter: FSM states, the
// packet word bundle and the per-source packet counter width.
package trafparser_pkg;

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        GAP
    } arb_state_t;

    // Same field order as the parser's delay register.
    typedef struct packed {
        logic [2:0]  mod;
        logic        sop;
        logic        eop;
        logic [63:0] data;
    } pkt_word_t;

    localparam int CNT_W = 32;

endpackage

// File: rtl/trafparser_rr_pick.sv
// Combinational round-robin picker: first requester strictly after
// 'last', wrapping; 'last' itself is considered last.
module trafparser_rr_pick
    import trafparser_pkg::*;
#(
    parameter int n_p = 4
) (
    input  logic [n_p-1:0]         req,
    input  logic [$clog2(n_p)-1:0] last,
    output logic [$clog2(n_p)-1:0] idx,
    output logic                   any
);

    localparam int IW = $clog2(n_p);

    always_comb begin
        idx = last;
        any = 1'b0;
        for (int off = 1; off <= n_p; off++) begin
            if (!any && req[(int'(last) + off) % n_p]) begin
                any = 1'b1;
                idx = IW'((int'(last) + off) % n_p);
            end
        end
    end

endmodule

// File: rtl/trafparser_src_arb.sv
// Packet-atomic round-robin merge of show-ahead source FIFOs into one
// strobe stream. Per-source packet counters under TRAFPARSER_ARB_CNT_EN.
module trafparser_src_arb
    import trafparser_pkg::*;
#(
    parameter int src_cnt_p = 4,
    parameter int gap_p     = 1
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          srst_i,
    input  logic                          en_i,
    input  logic [src_cnt_p-1:0]          src_req_i,
    input  logic [src_cnt_p-1:0]          src_val_i,
    input  logic [64*src_cnt_p-1:0]       src_data_i,
    input  logic [3*src_cnt_p-1:0]        src_mod_i,
    input  logic [src_cnt_p-1:0]          src_sop_i,
    input  logic [src_cnt_p-1:0]          src_eop_i,
    output logic [src_cnt_p-1:0]          src_rd_o,
    output logic [63:0]                   pkt_data_o,
    output logic [2:0]                    pkt_mod_o,
    output logic                          pkt_sop_o,
    output logic                          pkt_eop_o,
    output logic                          pkt_en_o,
    output logic [$clog2(src_cnt_p)-1:0]  grant_o,
    output logic                          busy_o,
`ifdef TRAFPARSER_ARB_CNT_EN
    output logic [CNT_W*src_cnt_p-1:0]    src_pkt_cnt_o,
`endif
    output logic                          sop_err_o
);

    localparam int GW = $clog2(src_cnt_p);
    localparam logic [1:0] GAP_LAST = (gap_p > 0) ? 2'(gap_p - 1) : 2'd0;

    arb_state_t state_q, state_d;
    logic [GW-1:0] grant_q, grant_d;
    logic [GW-1:0] rr_q, rr_d;
    logic [GW-1:0] pick_idx;
    logic          pick_any;
    logic [1:0]    gap_q, gap_d;
    logic          first_q, first_d;
    logic [src_cnt_p-1:0] rd;
    logic          pop;
    logic          pop_eop;
    pkt_word_t     head;
    pkt_word_t     word_q;
    logic          pen_q;
    logic          err_q;
    int            gi;

    trafparser_rr_pick #(
        .n_p (src_cnt_p)
    ) u_pick (
        .req  (src_req_i),
        .last (rr_q),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    always_comb begin
        gi        = int'(grant_q);
        head.mod  = src_mod_i[3*gi +: 3];
        head.sop  = src_sop_i[gi];
        head.eop  = src_eop_i[gi];
        head.data = src_data_i[64*gi +: 64];
    end

    // srst_i kills the pop in the same cycle it is seen.
    always_comb begin
        rd = '0;
        if (state_q == XFER && !srst_i) begin
            rd[grant_q] = src_val_i[grant_q];
        end
    end

    assign pop     = |rd;
    assign pop_eop = pop && head.eop;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        gap_d   = gap_q;
        first_d = first_q;
        unique case (state_q)
            IDLE: begin
                if (en_i && pick_any) begin
                    state_d = XFER;
                    grant_d = pick_idx;
                    first_d = 1'b1;
                end
            end
            XFER: begin
                if (pop) begin
                    first_d = 1'b0;
                end
                if (pop_eop) begin
                    rr_d    = grant_q;
                    gap_d   = 2'd0;
                    state_d = (gap_p > 0) ? GAP : IDLE;
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + 2'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            grant_q <= '0;
            rr_q    <= GW'(src_cnt_p - 1);
            gap_q   <= 2'd0;
            first_q <= 1'b0;
        end else if (srst_i) begin
            state_q <= IDLE;
            grant_q <= '0;
            rr_q    <= GW'(src_cnt_p - 1);
            gap_q   <= 2'd0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            gap_q   <= gap_d;
            first_q <= first_d;
        end
    end

    // Word fields hold between strobes; only the strobe drops.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            word_q <= '0;
            pen_q  <= 1'b0;
            err_q  <= 1'b0;
        end else if (srst_i) begin
            word_q <= '0;
            pen_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            pen_q <= pop;
            err_q <= pop && first_q && !head.sop;
            if (pop) begin
                word_q <= head;
            end
        end
    end

`ifdef TRAFPARSER_ARB_CNT_EN
    logic [CNT_W-1:0] cnt_q [src_cnt_p];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < src_cnt_p; k++) cnt_q[k] <= '0;
        end else if (srst_i) begin
            for (int k = 0; k < src_cnt_p; k++) cnt_q[k] <= '0;
        end else if (pop_eop && cnt_q[grant_q] != '1) begin
            cnt_q[grant_q] <= cnt_q[grant_q] + CNT_W'(1);
        end
    end

    for (genvar k = 0; k < src_cnt_p; k++) begin : g_cnt
        assign src_pkt_cnt_o[CNT_W*k +: CNT_W] = cnt_q[k];
    end
`endif

    assign src_rd_o   = rd;
    assign pkt_data_o = word_q.data;
    assign pkt_mod_o  = word_q.mod;
    assign pkt_sop_o  = word_q.sop;
    assign pkt_eop_o  = word_q.eop;
    assign pkt_en_o   = pen_q;
    assign sop_err_o  = err_q;
    assign grant_o    = grant_q;
    assign busy_o     = (state_q == XFER);

endmodule
